// File: rtl/light_pkg.sv
// light_pkg: shared definitions for the traffic-light conflict monitor.
//   - Lamp codes, one-hot except the left arrow which also shows red: [3] left,
//     [2] green, [1] yellow, [0] red.
//   - Fault cause codes reported on light_monitor.fault_code.
//   - Monitor FSM state encoding.
//   - Helpers: 5-bit saturating increment and fault cause priority encoder.
// Optional feature macro (used by the importing modules): LIGHT_MONITOR_YELLOW_CHECK_EN.
package light_pkg;

    localparam logic [3:0] LAMP_LEFT   = 4'b1001;
    localparam logic [3:0] LAMP_GREEN  = 4'b0100;
    localparam logic [3:0] LAMP_YELLOW = 4'b0010;
    localparam logic [3:0] LAMP_RED    = 4'b0001;

    localparam logic [2:0] FAULT_NONE         = 3'd0;
    localparam logic [2:0] FAULT_ILLEGAL      = 3'd1;
    localparam logic [2:0] FAULT_CONFLICT     = 3'd2;
    localparam logic [2:0] FAULT_OVERRUN      = 3'd3;
    localparam logic [2:0] FAULT_SHORT_YELLOW = 3'd4;

    typedef enum logic [1:0] {
        StMonitor = 2'd0,
        StPending = 2'd1,
        StFault   = 2'd2,
        StRecover = 2'd3
    } mon_state_e;

    // All internal counters are 5 bits and stick at 31 instead of wrapping.
    function automatic logic [4:0] sat_inc5(input logic [4:0] value);
        return (value == 5'd31) ? value : value + 5'd1;
    endfunction

    // Lower code wins when several causes are active in the same cycle.
    function automatic logic [2:0] fault_cause(
        input logic illegal,
        input logic conflict,
        input logic overrun,
        input logic short_yellow
    );
        if (illegal) begin
            return FAULT_ILLEGAL;
        end else if (conflict) begin
            return FAULT_CONFLICT;
        end else if (overrun) begin
            return FAULT_OVERRUN;
        end else if (short_yellow) begin
            return FAULT_SHORT_YELLOW;
        end
        return FAULT_NONE;
    endfunction

endpackage

// File: rtl/lamp_checker.sv
// lamp_checker: per-direction lamp legality and timing checks.
// Ports:
//   clock, reset      - rising-edge clock, synchronous active-high reset
//   active            - high while the monitor is checking (MONITOR/PENDING);
//                       when low the counters are held at 0 and events are masked
//   lamp[3:0]         - lamp code of this direction
//   illegal           - lamp code is not one of the four legal codes (raw level)
//   proceed           - lamp code is anything other than red (raw level)
//   overrun           - green has been on for more than MAX_GREEN cycles (event)
//   short_yellow      - red reached from green, or from a too-short yellow (event)
// Macro LIGHT_MONITOR_YELLOW_CHECK_EN compiles in the yellow counter, the previous
// lamp register and short_yellow detection; without it short_yellow is tied low.
module lamp_checker
    import light_pkg::*;
#(
    parameter int unsigned MAX_GREEN = 10
`ifdef LIGHT_MONITOR_YELLOW_CHECK_EN
    ,
    parameter int unsigned MIN_YELLOW = 3
`endif
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       active,
    input  logic [3:0] lamp,
    output logic       illegal,
    output logic       proceed,
    output logic       overrun,
    output logic       short_yellow
);

    localparam logic [4:0] MaxGreen = 5'(MAX_GREEN);

    logic [4:0] green_q;
    logic [4:0] green_d;

    // green_d is the run length including the current cycle.
    always_comb begin
        illegal = (lamp != LAMP_LEFT) && (lamp != LAMP_GREEN) &&
                  (lamp != LAMP_YELLOW) && (lamp != LAMP_RED);
        proceed = (lamp != LAMP_RED);
        green_d = 5'd0;
        if (active && (lamp == LAMP_GREEN)) begin
            green_d = sat_inc5(green_q);
        end
        overrun = active && (green_d > MaxGreen);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            green_q <= 5'd0;
        end else begin
            green_q <= green_d;
        end
    end

`ifdef LIGHT_MONITOR_YELLOW_CHECK_EN
    localparam logic [4:0] MinYellow = 5'(MIN_YELLOW);

    logic [4:0] yellow_q;
    logic [4:0] yellow_d;
    logic [3:0] prev_q;

    // On the first red cycle yellow_q still holds the length of the yellow run
    // that just ended, because yellow_d only clears from this cycle onwards.
    always_comb begin
        yellow_d = 5'd0;
        if (active && (lamp == LAMP_YELLOW)) begin
            yellow_d = sat_inc5(yellow_q);
        end
        short_yellow = active && (lamp == LAMP_RED) &&
                       ((prev_q == LAMP_GREEN) ||
                        ((prev_q == LAMP_YELLOW) && (yellow_q < MinYellow)));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            yellow_q <= 5'd0;
            prev_q   <= LAMP_RED;
        end else begin
            yellow_q <= yellow_d;
            prev_q   <= lamp;
        end
    end
`else
    assign short_yellow = 1'b0;
`endif

endmodule

// File: rtl/light_monitor.sv
// light_monitor: conflict monitor for a two-direction traffic light pair.
// Watches both lamp codes, filters level violations (illegal code, conflicting
// proceed) over PERSIST cycles, reacts immediately to timing events (green
// overrun, short yellow), latches a fault cause and drives a registered
// emergency output until the operator clears and a HOLD-cycle all-stop ends.
// Ports:
//   clock, reset      - rising-edge clock, synchronous active-high reset
//   ns_lamp[3:0]      - north-south lamp code
//   ew_lamp[3:0]      - east-west lamp code
//   clear             - fault acknowledge, only honoured in FAULT
//   emergency         - high in FAULT and RECOVER
//   fault             - high while a fault is latched
//   fault_code[2:0]   - latched cause (0 none, 1 illegal, 2 conflict, 3 overrun,
//                       4 short yellow)
//   fault_count[7:0]  - faults since reset, saturating at 255
// Macro LIGHT_MONITOR_YELLOW_CHECK_EN enables short-yellow detection; without it
// fault code 4 is never produced.
module light_monitor
    import light_pkg::*;
#(
    parameter int unsigned MAX_GREEN  = 10,
    parameter int unsigned MIN_YELLOW = 3,
    parameter int unsigned PERSIST    = 2,
    parameter int unsigned HOLD       = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] ns_lamp,
    input  logic [3:0] ew_lamp,
    input  logic       clear,
    output logic       emergency,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [7:0] fault_count
);

    if ((MAX_GREEN == 0) || (MAX_GREEN > 30) || (MIN_YELLOW == 0) || (MIN_YELLOW > 30) ||
        (PERSIST == 0) || (PERSIST > 15) || (HOLD == 0) || (HOLD > 15)) begin : g_param_check
        $error("light_monitor: parameter out of range");
    end

    localparam logic [4:0] PersistLim = 5'(PERSIST);
    localparam logic [4:0] HoldInit   = 5'(HOLD);

    mon_state_e state_q;
    logic [4:0] persist_q;
    logic [4:0] hold_q;

    logic active;
    logic ns_illegal, ns_proceed, ns_overrun, ns_short;
    logic ew_illegal, ew_proceed, ew_overrun, ew_short;
    logic any_illegal, any_conflict, any_overrun, any_short;
    logic level_viol, any_event, go_fault;
    logic [2:0] cause;

    assign active = (state_q == StMonitor) || (state_q == StPending);

    lamp_checker #(
        .MAX_GREEN    (MAX_GREEN)
`ifdef LIGHT_MONITOR_YELLOW_CHECK_EN
        ,
        .MIN_YELLOW   (MIN_YELLOW)
`endif
    ) u_ns_checker (
        .clock        (clock),
        .reset        (reset),
        .active       (active),
        .lamp         (ns_lamp),
        .illegal      (ns_illegal),
        .proceed      (ns_proceed),
        .overrun      (ns_overrun),
        .short_yellow (ns_short)
    );

    lamp_checker #(
        .MAX_GREEN    (MAX_GREEN)
`ifdef LIGHT_MONITOR_YELLOW_CHECK_EN
        ,
        .MIN_YELLOW   (MIN_YELLOW)
`endif
    ) u_ew_checker (
        .clock        (clock),
        .reset        (reset),
        .active       (active),
        .lamp         (ew_lamp),
        .illegal      (ew_illegal),
        .proceed      (ew_proceed),
        .overrun      (ew_overrun),
        .short_yellow (ew_short)
    );

    // Level causes are masked here; the checkers already mask their events.
    always_comb begin
        any_illegal  = active && (ns_illegal || ew_illegal);
        any_conflict = active && ns_proceed && ew_proceed;
        any_overrun  = ns_overrun || ew_overrun;
        any_short    = ns_short || ew_short;
        level_viol   = any_illegal || any_conflict;
        any_event    = any_overrun || any_short;
        cause        = fault_cause(any_illegal, any_conflict, any_overrun, any_short);
    end

    // Fault entry condition; in PENDING the current cycle is the (persist_q+1)-th.
    always_comb begin
        go_fault = 1'b0;
        unique case (state_q)
            StMonitor: go_fault = any_event || (level_viol && (PERSIST == 1));
            StPending: go_fault = any_event || (level_viol && (persist_q >= PersistLim - 5'd1));
            default:   go_fault = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StMonitor;
            persist_q   <= 5'd0;
            hold_q      <= 5'd0;
            emergency   <= 1'b0;
            fault       <= 1'b0;
            fault_code  <= FAULT_NONE;
            fault_count <= 8'd0;
        end else if (go_fault) begin
            state_q     <= StFault;
            persist_q   <= 5'd0;
            emergency   <= 1'b1;
            fault       <= 1'b1;
            fault_code  <= cause;
            if (fault_count != 8'hFF) begin
                fault_count <= fault_count + 8'd1;
            end
        end else begin
            unique case (state_q)
                StMonitor: begin
                    if (level_viol) begin
                        state_q   <= StPending;
                        persist_q <= 5'd1;
                    end
                end
                StPending: begin
                    if (level_viol) begin
                        persist_q <= sat_inc5(persist_q);
                    end else begin
                        state_q   <= StMonitor;
                        persist_q <= 5'd0;
                    end
                end
                StFault: begin
                    if (clear) begin
                        state_q    <= StRecover;
                        fault      <= 1'b0;
                        fault_code <= FAULT_NONE;
                        hold_q     <= HoldInit;
                    end
                end
                StRecover: begin
                    // hold_q == 1 marks the last of the HOLD all-stop cycles.
                    if (hold_q <= 5'd1) begin
                        state_q   <= StMonitor;
                        hold_q    <= 5'd0;
                        emergency <= 1'b0;
                    end else begin
                        hold_q <= hold_q - 5'd1;
                    end
                end
                default: begin
                    state_q <= StMonitor;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_light_monitor.sv
// tb_light_monitor: directed self-checking bench for light_monitor with default
// parameters (MAX_GREEN 10, MIN_YELLOW 3, PERSIST 2, HOLD 4). Short-yellow
// expectations follow LIGHT_MONITOR_YELLOW_CHECK_EN.
module tb_light_monitor;

    localparam logic [3:0] LEFT   = 4'b1001;
    localparam logic [3:0] GREEN  = 4'b0100;
    localparam logic [3:0] YELLOW = 4'b0010;
    localparam logic [3:0] RED    = 4'b0001;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] ns_lamp = RED;
    logic [3:0] ew_lamp = RED;
    logic       clear = 1'b0;
    logic       emergency;
    logic       fault;
    logic [2:0] fault_code;
    logic [7:0] fault_count;

    int checks = 0;
    int passes = 0;

    logic       exp_sy_em;
    logic [2:0] exp_sy_code;

    light_monitor dut (
        .clock       (clock),
        .reset       (reset),
        .ns_lamp     (ns_lamp),
        .ew_lamp     (ew_lamp),
        .clear       (clear),
        .emergency   (emergency),
        .fault       (fault),
        .fault_code  (fault_code),
        .fault_count (fault_count)
    );

    always #5 clock = ~clock;

    // Apply one cycle of lamp codes; outputs are observed 1 ns after the edge.
    task automatic tick(input logic [3:0] ns, input logic [3:0] ew);
        ns_lamp = ns;
        ew_lamp = ew;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        clear = 1'b0;
        reset = 1'b1;
        tick(RED, RED);
        tick(RED, RED);
        reset = 1'b0;
    endtask

    function automatic logic [3:0] phase_lamp(input int p);
        if (p < 5)  return LEFT;
        if (p < 15) return GREEN;
        if (p < 18) return YELLOW;
        return RED;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        clear = 1'b1;
        for (int i = 0; i < 3; i++) tick(GREEN, GREEN);
        checks++; if (emergency !== 1'b0) $display("FAIL reset_emergency: got %0b expected 0", emergency); else passes++;
        checks++; if (fault !== 1'b0) $display("FAIL reset_fault: got %0b expected 0", fault); else passes++;
        checks++; if (fault_code !== 3'd0) $display("FAIL reset_code: got %0d expected 0", fault_code); else passes++;
        checks++; if (fault_count !== 8'd0) $display("FAIL reset_count: got %0d expected 0", fault_count); else passes++;
        clear = 1'b0;
        reset = 1'b0;
        tick(RED, RED);
    endtask

    task automatic test_normal_sequence();
        logic em_seen;
        do_reset();
        em_seen = 1'b0;
        for (int t = 0; t < 200; t++) begin
            tick(phase_lamp(t % 36), phase_lamp((t + 18) % 36));
            em_seen = em_seen | emergency;
        end
        checks++; if (em_seen !== 1'b0) $display("FAIL normal_emergency: got %0b expected 0", em_seen); else passes++;
        checks++; if (fault_count !== 8'd0) $display("FAIL normal_count: got %0d expected 0", fault_count); else passes++;
    endtask

    task automatic test_conflict();
        do_reset();
        tick(GREEN, GREEN);
        checks++; if (emergency !== 1'b0) $display("FAIL conflict_1cyc_em: got %0b expected 0", emergency); else passes++;
        do_reset();
        tick(LEFT, LEFT);
        tick(LEFT, RED);
        tick(LEFT, RED);
        checks++; if (fault !== 1'b0) $display("FAIL conflict_filtered_fault: got %0b expected 0", fault); else passes++;
        do_reset();
        tick(GREEN, GREEN);
        tick(GREEN, GREEN);
        checks++; if (emergency !== 1'b1) $display("FAIL conflict_2cyc_em: got %0b expected 1", emergency); else passes++;
        checks++; if (fault !== 1'b1) $display("FAIL conflict_2cyc_fault: got %0b expected 1", fault); else passes++;
        checks++; if (fault_code !== 3'd2) $display("FAIL conflict_code: got %0d expected 2", fault_code); else passes++;
        checks++; if (fault_count !== 8'd1) $display("FAIL conflict_count: got %0d expected 1", fault_count); else passes++;
    endtask

    task automatic test_illegal();
        do_reset();
        tick(4'b0110, RED);
        tick(RED, RED);
        tick(RED, RED);
        checks++; if (emergency !== 1'b0) $display("FAIL illegal_1cyc_em: got %0b expected 0", emergency); else passes++;
        do_reset();
        tick(4'b0110, GREEN);
        checks++; if (emergency !== 1'b0) $display("FAIL illegal_first_em: got %0b expected 0", emergency); else passes++;
        tick(4'b0110, GREEN);
        checks++; if (emergency !== 1'b1) $display("FAIL illegal_em: got %0b expected 1", emergency); else passes++;
        checks++; if (fault_code !== 3'd1) $display("FAIL illegal_over_conflict: got %0d expected 1", fault_code); else passes++;
        do_reset();
        tick(4'b0000, RED);
        tick(4'b0000, RED);
        checks++; if (fault_code !== 3'd1) $display("FAIL illegal_dark_ns: got %0d expected 1", fault_code); else passes++;
        do_reset();
        tick(RED, 4'b1111);
        tick(RED, 4'b1111);
        checks++; if (fault_code !== 3'd1) $display("FAIL illegal_all_ew: got %0d expected 1", fault_code); else passes++;
    endtask

    task automatic test_overrun();
        do_reset();
        for (int i = 0; i < 10; i++) tick(GREEN, RED);
        checks++; if (emergency !== 1'b0) $display("FAIL overrun_at_max_em: got %0b expected 0", emergency); else passes++;
        tick(GREEN, RED);
        checks++; if (emergency !== 1'b1) $display("FAIL overrun_ns_em: got %0b expected 1", emergency); else passes++;
        checks++; if (fault_code !== 3'd3) $display("FAIL overrun_ns_code: got %0d expected 3", fault_code); else passes++;
        do_reset();
        for (int i = 0; i < 11; i++) tick(RED, GREEN);
        checks++; if (fault_code !== 3'd3) $display("FAIL overrun_ew_code: got %0d expected 3", fault_code); else passes++;
    endtask

    task automatic test_short_yellow();
        do_reset();
        tick(GREEN, RED);
        for (int i = 0; i < 3; i++) tick(YELLOW, RED);
        tick(RED, RED);
        tick(RED, RED);
        checks++; if (emergency !== 1'b0) $display("FAIL yellow_full_em: got %0b expected 0", emergency); else passes++;
        tick(GREEN, RED);
        tick(YELLOW, RED);
        tick(YELLOW, RED);
        tick(RED, RED);
        checks++; if (emergency !== exp_sy_em) $display("FAIL yellow_short_em: got %0b expected %0b", emergency, exp_sy_em); else passes++;
        checks++; if (fault_code !== exp_sy_code) $display("FAIL yellow_short_code: got %0d expected %0d", fault_code, exp_sy_code); else passes++;
        do_reset();
        tick(RED, GREEN);
        tick(RED, RED);
        checks++; if (fault_code !== exp_sy_code) $display("FAIL green_to_red_code: got %0d expected %0d", fault_code, exp_sy_code); else passes++;
    endtask

    task automatic test_clear_recover();
        logic em_drop;
        do_reset();
        clear = 1'b1;
        tick(RED, RED);
        clear = 1'b0;
        tick(GREEN, GREEN);
        tick(GREEN, GREEN);
        for (int i = 0; i < 3; i++) tick(GREEN, GREEN);
        checks++; if (fault_count !== 8'd1) $display("FAIL fault_hold_count: got %0d expected 1", fault_count); else passes++;
        checks++; if (fault_code !== 3'd2) $display("FAIL fault_hold_code: got %0d expected 2", fault_code); else passes++;
        clear = 1'b1;
        tick(GREEN, GREEN);
        clear = 1'b0;
        checks++; if (fault !== 1'b0) $display("FAIL clear_fault: got %0b expected 0", fault); else passes++;
        checks++; if (fault_code !== 3'd0) $display("FAIL clear_code: got %0d expected 0", fault_code); else passes++;
        checks++; if (emergency !== 1'b1) $display("FAIL clear_em: got %0b expected 1", emergency); else passes++;
        em_drop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(RED, RED);
            em_drop = em_drop | ~emergency;
        end
        checks++; if (em_drop !== 1'b0) $display("FAIL recover_hold_em: got drop %0b expected 0", em_drop); else passes++;
        tick(RED, RED);
        checks++; if (emergency !== 1'b0) $display("FAIL recover_exit_em: got %0b expected 0", emergency); else passes++;
        tick(GREEN, GREEN);
        tick(GREEN, GREEN);
        checks++; if (fault_count !== 8'd2) $display("FAIL refault_count: got %0d expected 2", fault_count); else passes++;
    endtask

    task automatic test_reset_in_recover();
        do_reset();
        tick(GREEN, GREEN);
        tick(GREEN, GREEN);
        clear = 1'b1;
        tick(RED, RED);
        clear = 1'b0;
        tick(RED, RED);
        reset = 1'b1;
        tick(RED, RED);
        reset = 1'b0;
        checks++; if (emergency !== 1'b0) $display("FAIL reset_recover_em: got %0b expected 0", emergency); else passes++;
        checks++; if (fault_count !== 8'd0) $display("FAIL reset_recover_count: got %0d expected 0", fault_count); else passes++;
    endtask

    task automatic test_reset_in_pending();
        do_reset();
        tick(4'b0110, RED);
        reset = 1'b1;
        tick(4'b0110, RED);
        reset = 1'b0;
        tick(4'b0110, RED);
        checks++; if (emergency !== 1'b0) $display("FAIL reset_pending_em: got %0b expected 0", emergency); else passes++;
        tick(4'b0110, RED);
        checks++; if (fault_code !== 3'd1) $display("FAIL reset_pending_code: got %0d expected 1", fault_code); else passes++;
    endtask

    task automatic test_saturation();
        logic [7:0] c1, c255, c256;
        do_reset();
        c1 = 8'd0;
        c255 = 8'd0;
        c256 = 8'd0;
        for (int n = 1; n <= 256; n++) begin
            tick(4'b0000, RED);
            tick(4'b0000, RED);
            if (n == 1) c1 = fault_count;
            if (n == 255) c255 = fault_count;
            if (n == 256) c256 = fault_count;
            clear = 1'b1;
            tick(RED, RED);
            clear = 1'b0;
            for (int i = 0; i < 4; i++) tick(RED, RED);
        end
        checks++; if (c1 !== 8'd1) $display("FAIL sat_first: got %0d expected 1", c1); else passes++;
        checks++; if (c255 !== 8'd255) $display("FAIL sat_255: got %0d expected 255", c255); else passes++;
        checks++; if (c256 !== 8'd255) $display("FAIL sat_256: got %0d expected 255", c256); else passes++;
    endtask

    initial begin
`ifdef LIGHT_MONITOR_YELLOW_CHECK_EN
        exp_sy_em   = 1'b1;
        exp_sy_code = 3'd4;
`else
        exp_sy_em   = 1'b0;
        exp_sy_code = 3'd0;
`endif
        test_reset();
        test_normal_sequence();
        test_conflict();
        test_illegal();
        test_overrun();
        test_short_yellow();
        test_clear_recover();
        test_reset_in_recover();
        test_reset_in_pending();
        test_saturation();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
